// File: rtl/init_pop.sv
// init_pop: builds a pseudo-random population of NUM_PATHS individuals of
// PATH_BITS each. It writes one CHUNK_BITS slice per cycle, taken from an
// xorshift32 generator that is seeded when start is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a new population (sampled on the rising edge)
//   prg_seed   32-bit seed captured with an accepted start (0 -> 32'h2545F491)
//   population registered population; individual i is
//              [PATH_BITS*i +: PATH_BITS]
//   done       one-cycle pulse after the last chunk has been written
//   busy       high while filling (only when INIT_POP_RESTART_EN is defined)
//
// Optional feature: macro INIT_POP_RESTART_EN adds busy. It also lets start
// restart a fill that is in progress. In the default build, start is ignored
// while filling.

// One population chunk. It holds its value unless it is selected for a write.
module init_pop_chunk #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= din;
  end
endmodule

module init_pop #(
  parameter int NUM_PATHS  = 50,
  parameter int PATH_BITS  = 150,
  parameter int CHUNK_BITS = 30
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [31:0]                    prg_seed,
  output logic [NUM_PATHS*PATH_BITS-1:0] population,
  output logic                           done
`ifdef INIT_POP_RESTART_EN
  ,output logic                          busy
`endif
);

  localparam int NCHUNK = NUM_PATHS * PATH_BITS / CHUNK_BITS;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST      = CW'(NCHUNK - 1);
  localparam logic [31:0]   SEED_DFLT = 32'h2545F491;

`ifdef INIT_POP_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state, state_n;
  logic [31:0]   x, x_nxt;
  logic [CW-1:0] cnt;
  logic          load, wr, fin;

  function automatic logic [31:0] xorshift32(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign x_nxt = xorshift32(x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // load: reseed and rewind. wr: emit one chunk. fin: the last chunk goes out.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    wr      = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        // A restart takes priority over the write. It takes priority even on
        // the final chunk, so no done pulse is produced for the aborted fill.
        if (RESTART_EN && start) begin
          load = 1'b1;
        end else begin
          wr = 1'b1;
          if (cnt == LAST) begin
            fin     = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= SEED_DFLT;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        x   <= (prg_seed == 32'd0) ? SEED_DFLT : prg_seed;
        cnt <= '0;
      end else if (wr) begin
        x   <= x_nxt;
        // The counter wraps on the last chunk so it never holds an index past NCHUNK-1.
        cnt <= fin ? '0 : cnt + 1'b1;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NCHUNK; k++) begin : g_chunk
      localparam logic [CW-1:0] KIDX = CW'(k);
      init_pop_chunk #(.W(CHUNK_BITS)) u_chunk (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr && (cnt == KIDX)),
        .din   (x_nxt[CHUNK_BITS-1:0]),
        .q     (population[CHUNK_BITS*k +: CHUNK_BITS])
      );
    end
  endgenerate

`ifdef INIT_POP_RESTART_EN
  assign busy = (state == FILL);
`endif

endmodule

// File: tb/tb_init_pop.sv
module tb_init_pop;
  localparam int NP = 50, PB = 150, CB = 30;
  localparam int NC = NP * PB / CB;
  localparam int W  = NP * PB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  prg_seed = 32'd0;
  logic [W-1:0] population;
  logic         done;
`ifdef INIT_POP_RESTART_EN
  logic         busy;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  init_pop #(.NUM_PATHS(NP), .PATH_BITS(PB), .CHUNK_BITS(CB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .prg_seed   (prg_seed),
    .population (population),
    .done       (done)
`ifdef INIT_POP_RESTART_EN
    ,.busy      (busy)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    t ^= t << 13;
    t ^= t >> 17;
    t ^= t << 5;
    return t;
  endfunction

  function automatic logic [W-1:0] model(input logic [31:0] seed);
    logic [W-1:0] p;
    logic [31:0]  s;
    p = '0;
    s = (seed == 32'd0) ? 32'h2545F491 : seed;
    for (int c = 0; c < NC; c++) begin
      s = xs(s);
      p[c*CB +: CB] = s[CB-1:0];
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Pop the oldest expected population and compare it against the DUT.
  task automatic sb_pop(input string tag);
    logic [W-1:0] e;
    compared++;
    assert (exp_q.size() > 0) else begin
      mismatched++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_pop(tag, population, e);
    end
  endtask

  // Tick until done is seen or limit expires; n counts edges since T0.
  task automatic run_to_done(input int limit, inout int n);
    for (int i = 0; i < limit; i++) begin
      tick();
      n++;
      if (done === 1'b1) return;
    end
    n = -1;
  endtask

  initial begin
    int n, n1, n2, dcount;
    logic [31:0] s;
    logic [W-1:0] first;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_pop("reset_pop", population, '0);
    chk("reset_done", done, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_done", done, 1'b0);
    chk_pop("idle_pop", population, '0);

    // seed = 1
    prg_seed = 32'd1; start = 1'b1;
    exp_q.push_back(model(32'd1));
    tick(); n = 0;
    start = 1'b0;
    tick(); n++;
    chk("seed1_chunk0", population[CB-1:0], 30'h0004_2021);
    run_to_done(400, n);
    chk("seed1_done_edge", n, 250);
    sb_pop("seed1_pop");
    tick();
    chk("seed1_done_pulse", done, 1'b0);

    // seed = 0 falls back to the default seed
    prg_seed = 32'd0; start = 1'b1;
    exp_q.push_back(model(32'd0));
    tick(); n = 0;
    start = 1'b0;
    tick(); n++;
    s = xs(32'h2545F491);
    chk("seed0_chunk0", population[CB-1:0], s[CB-1:0]);
    run_to_done(400, n);
    chk("seed0_done_edge", n, 250);
    sb_pop("seed0_pop");
    chk("seed0_nonzero", population != '0, 1'b1);
    tick();

`ifdef INIT_POP_RESTART_EN
    // Restart at T0+100 with seed 1
    prg_seed = 32'h1234_5678; start = 1'b1;
    tick(); n = 0;
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 99; i++) begin
      tick(); n++;
      if (busy !== 1'b1) dcount++;
    end
    prg_seed = 32'd1; start = 1'b1;
    exp_q.push_back(model(32'd1));
    tick(); n++;
    start = 1'b0;
    if (busy !== 1'b1) dcount++;
    tick(); n++;
    chk("restart_chunk0", population[CB-1:0], 30'h0004_2021);
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) break;
      if (busy !== 1'b1) dcount++;
      tick(); n++;
    end
    chk("restart_busy_low", dcount, 0);
    chk("restart_done_edge", n, 350);
    sb_pop("restart_pop");
    tick();
`else
    // Start pulses during FILL are ignored
    prg_seed = 32'd5; start = 1'b1;
    exp_q.push_back(model(32'd5));
    tick(); n = 0;
    start = 1'b0;
    for (int i = 0; i < 49; i++) begin tick(); n++; end
    prg_seed = 32'hABCD; start = 1'b1;
    tick(); n++;
    start = 1'b0;
    for (int i = 0; i < 69; i++) begin tick(); n++; end
    prg_seed = 32'h0; start = 1'b1;
    tick(); n++;
    start = 1'b0;
    prg_seed = 32'd5;
    run_to_done(400, n);
    chk("ignore_done_edge", n, 250);
    sb_pop("ignore_pop");
    tick();
`endif

    // Reset in the middle of a fill
    prg_seed = 32'd9; start = 1'b1;
    tick(); n = 0;
    start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    rst_n = 1'b0;
    #1;
    chk_pop("midrst_pop", population, '0);
    chk("midrst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done !== 1'b0) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    chk_pop("midrst_stays_idle", population, '0);

    // start held high: back-to-back generations
    prg_seed = 32'd3; start = 1'b1;
    exp_q.push_back(model(32'd3));
    exp_q.push_back(model(32'd3));
    tick(); n = 0;
    n1 = -1; n2 = -1;
    first = '0;
    for (int i = 0; i < 600; i++) begin
      tick(); n++;
      if (done === 1'b1) begin
        if (n1 < 0) begin
          n1 = n; first = population;
          sb_pop("held_pop1");
        end else if (n2 < 0) begin
          n2 = n;
          sb_pop("held_pop2");
          chk_pop("held_same", population, first);
        end
      end
    end
    start = 1'b0;
    chk("held_done1_edge", n1, 250);
    chk("held_done2_edge", n2, 501);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
